// File: rtl/res_arbiter.sv
// res_arbiter: round-robin arbiter sharing one datapath resource between four
// requesters. Grants are one-hot and registered. An owner holds the grant until it
// drops its request or reaches MAX_HOLD consecutive cycles. Every handover passes
// through a one-cycle all-zero gap.
module res_arbiter #(
    parameter int unsigned MAX_HOLD = 8  // legal range 1..15
) (
    input  logic       clk,
    input  logic       reset,    // asynchronous, active-low
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] owner,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

    state_e     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] hold_q, hold_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] owner_q, owner_d;
    logic       timeout_q, timeout_d;

    logic       found;
    logic [1:0] sel;
    logic [1:0] scan_idx;

    // Round-robin scan starting at ptr. Walking downwards lets the lowest offset win.
    always_comb begin
        found    = 1'b0;
        sel      = ptr_q;
        scan_idx = ptr_q;
        for (int i = 3; i >= 0; i--) begin
            scan_idx = ptr_q + 2'(i);
            if (req[scan_idx]) begin
                found = 1'b1;
                sel   = scan_idx;
            end
        end
    end

    // Next-state logic: grant, release (normal or forced), gap and idle.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        timeout_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    grant_d = 4'b0001 << sel;
                    owner_d = sel;
                    hold_d  = 4'd1;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                if (!req[owner_q]) begin
                    // A request drop wins over the hold limit, so there is no timeout.
                    grant_d = 4'b0000;
                    ptr_d   = owner_q + 2'd1;
                    state_d = StGap;
                end else if (hold_q == 4'(MAX_HOLD)) begin
                    grant_d   = 4'b0000;
                    ptr_d     = owner_q + 2'd1;
                    timeout_d = 1'b1;
                    state_d   = StGap;
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end
            StGap: begin
                if (found) begin
                    grant_d = 4'b0001 << sel;
                    owner_d = sel;
                    hold_d  = 4'd1;
                    state_d = StGrant;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                grant_d = 4'b0000;
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            ptr_q     <= 2'd0;
            hold_q    <= 4'd0;
            grant_q   <= 4'b0000;
            owner_q   <= 2'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant   = grant_q;
    assign busy    = |grant_q;
    // owner reads zero whenever nobody holds the grant.
    assign owner   = busy ? owner_q : 2'd0;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_res_arbiter.sv
// tb_res_arbiter: directed scoreboard bench. Stimulus pushes the hand-computed
// outputs expected after the next clock edge, or right after an asynchronous reset.
// A separate monitor pops each entry and compares it with the selected instance.
module tb_res_arbiter;

    typedef struct packed {
        logic       sel;   // 0: MAX_HOLD=8 instance, 1: MAX_HOLD=4 instance
        logic [3:0] g;
        logic [1:0] o;
        logic       t;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [3:0] req8, req4;
    logic [3:0] g8, g4;
    logic [1:0] o8, o4;
    logic       b8, b4, t8, t4;

    exp_t exp_q[$];
    int   n_tests;
    int   n_fail;

    res_arbiter #(.MAX_HOLD(8)) dut8 (
        .clk(clk), .reset(reset), .req(req8),
        .grant(g8), .owner(o8), .busy(b8), .timeout(t8)
    );

    res_arbiter #(.MAX_HOLD(4)) dut4 (
        .clk(clk), .reset(reset), .req(req4),
        .grant(g4), .owner(o4), .busy(b4), .timeout(t4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input logic s, input logic [3:0] g, input logic [1:0] o,
                        input logic t);
        exp_t e;
        e.sel = s;
        e.g   = g;
        e.o   = o;
        e.t   = t;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of request and record what must appear after the next edge.
    task automatic step(input logic s, input logic [3:0] r, input logic [3:0] g,
                        input logic [1:0] o, input logic t);
        @(negedge clk);
        req8 = s ? 4'b0000 : r;
        req4 = s ? r : 4'b0000;
        push(s, g, o, t);
    endtask

    // Monitor: compare after every clock edge and every reset assertion.
    initial begin
        exp_t       e;
        logic [3:0] ag;
        logic [1:0] ao;
        logic       ab, at;
        forever begin
            @(posedge clk or negedge reset);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                ag = e.sel ? g4 : g8;
                ao = e.sel ? o4 : o8;
                ab = e.sel ? b4 : b8;
                at = e.sel ? t4 : t8;
                n_tests++;
                if (ag !== e.g || ao !== e.o || ab !== (|e.g) || at !== e.t) begin
                    n_fail++;
                    $display("FAIL outputs dut%0d t=%0t: got grant=%b owner=%0d busy=%b timeout=%b, want grant=%b owner=%0d busy=%b timeout=%b",
                             e.sel ? 4 : 8, $time, ag, ao, ab, at, e.g, e.o, |e.g, e.t);
                end
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        req8    = 4'b0000;
        req4    = 4'b0000;

        // Reset state.
        step(0, 4'b0000, 4'b0000, 2'd0, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // Saturation: 8-cycle grants rotating 0,1,2,3,0; each gap carries a timeout.
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 8; c++) step(0, 4'b1111, 4'(1 << k), 2'(k), 1'b0);
            step(0, 4'b1111, 4'b0000, 2'd0, 1'b1);
        end
        for (int c = 0; c < 8; c++) step(0, 4'b1111, 4'b0001, 2'd0, 1'b0);
        // Drop coincides with hold limit: normal release, no timeout.
        step(0, 4'b0000, 4'b0000, 2'd0, 1'b0);
        step(0, 4'b0000, 4'b0000, 2'd0, 1'b0);

        // Single requester 2 for three cycles (ptr=1).
        for (int c = 0; c < 3; c++) step(0, 4'b0100, 4'b0100, 2'd2, 1'b0);
        step(0, 4'b0000, 4'b0000, 2'd0, 1'b0);
        step(0, 4'b0000, 4'b0000, 2'd0, 1'b0);

        // Asynchronous reset during an active grant of requester 2.
        step(0, 4'b0100, 4'b0100, 2'd2, 1'b0);
        step(0, 4'b0100, 4'b0100, 2'd2, 1'b0);
        @(negedge clk);
        #2;
        push(0, 4'b0000, 2'd0, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        req8  = 4'b1010;
        push(0, 4'b0010, 2'd1, 1'b0);
        step(0, 4'b0000, 4'b0000, 2'd0, 1'b0);
        step(0, 4'b0000, 4'b0000, 2'd0, 1'b0);

        // Rotation: owner 1 releases, ptr=2, so requester 0 wins over requester 1.
        step(0, 4'b0010, 4'b0010, 2'd1, 1'b0);
        step(0, 4'b0010, 4'b0010, 2'd1, 1'b0);
        step(0, 4'b0001, 4'b0000, 2'd0, 1'b0);
        step(0, 4'b0011, 4'b0001, 2'd0, 1'b0);
        step(0, 4'b0000, 4'b0000, 2'd0, 1'b0);
        step(0, 4'b0000, 4'b0000, 2'd0, 1'b0);

        // Idle path: later request from requester 3 granted after one edge.
        step(0, 4'b0000, 4'b0000, 2'd0, 1'b0);
        step(0, 4'b1000, 4'b1000, 2'd3, 1'b0);
        step(0, 4'b1000, 4'b1000, 2'd3, 1'b0);
        step(0, 4'b0000, 4'b0000, 2'd0, 1'b0);
        step(0, 4'b0000, 4'b0000, 2'd0, 1'b0);

        // MAX_HOLD=4 tie: owner 0 drops req exactly when hold reaches 4.
        for (int c = 0; c < 4; c++) step(1, 4'b0001, 4'b0001, 2'd0, 1'b0);
        step(1, 4'b0000, 4'b0000, 2'd0, 1'b0);
        step(1, 4'b0000, 4'b0000, 2'd0, 1'b0);

        // MAX_HOLD=4 forced release; non-owner requester 1 waits, then wins (ptr=1).
        step(1, 4'b0001, 4'b0001, 2'd0, 1'b0);
        for (int c = 0; c < 3; c++) step(1, 4'b0011, 4'b0001, 2'd0, 1'b0);
        step(1, 4'b0011, 4'b0000, 2'd0, 1'b1);
        step(1, 4'b0011, 4'b0010, 2'd1, 1'b0);
        step(1, 4'b0000, 4'b0000, 2'd0, 1'b0);
        step(1, 4'b0000, 4'b0000, 2'd0, 1'b0);

        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left unchecked, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
